// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit.
// Condition codes, {N,Z,C,V} bit positions and the predicate-block
// FSM state type. Imported by cond_eval and cond_logic_unit.
package cond_pkg;

    localparam logic [2:0] COND_EQ = 3'b000;
    localparam logic [2:0] COND_MI = 3'b001;
    localparam logic [2:0] COND_GT = 3'b010;
    localparam logic [2:0] COND_AL = 3'b111;

    // bit positions inside the 4-bit {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } pblk_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition decode.
// Ports:
//   cond  [2:0] in   condition code (EQ, MI, GT, AL; others never pass)
//   flags [3:0] in   {N,Z,C,V}
//   pass        out  condition satisfied
module cond_eval
    import cond_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    // carry is not consulted by any supported condition
    logic unused_c;
    assign unused_c = flags[FLAG_C];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = flags[FLAG_Z];
            COND_MI: pass = flags[FLAG_N];
            COND_GT: pass = ~flags[FLAG_Z] & (flags[FLAG_N] == flags[FLAG_V]);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic_unit.sv
// Conditional-execution control: gates register/memory/branch requests by
// the evaluated condition, holds the {N,Z,C,V} flags and, when the macro
// COND_PBLK_EN is defined, runs a predicate-block FSM that applies one
// latched condition to the next 1..MAX_PBLK retired instructions.
// Without COND_PBLK_EN, pblk_start/pblk_len are ignored and pblk_active is 0.
// Ports:
//   clk, reset (async, active-low)
//   instr_valid, cond[2:0], alu_flags[3:0], flag_w[1:0]
//   pcs, reg_w, mem_w, no_write, pblk_start, pblk_len[1:0]   inputs
//   pc_src, reg_write, mem_write, cond_ex, flags[3:0], pblk_active outputs
//
// state     | meaning
// ST_IDLE   | no block; cond input governs execution
// ST_ACTIVE | inside block; latched block condition governs execution
module cond_logic_unit
    import cond_pkg::*;
#(
    parameter int MAX_PBLK = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [2:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       pblk_start,
    input  logic [1:0] pblk_len,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic [3:0] flags,
    output logic       pblk_active
);

    logic [3:0] flags_q, flags_d;
    logic [2:0] eff_cond;
    logic       start_instr;
    logic       exec;

    cond_eval u_cond_eval (
        .cond  (eff_cond),
        .flags (flags_q),
        .pass  (cond_ex)
    );

`ifdef COND_PBLK_EN
    localparam logic [1:0] MAX_LEN = 2'(MAX_PBLK);

    pblk_state_e state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [2:0]  blk_cond_q, blk_cond_d;

    assign start_instr = (state_q == ST_IDLE) & pblk_start & instr_valid
                         & (pblk_len != 2'd0);
    assign eff_cond    = (state_q == ST_ACTIVE) ? blk_cond_q : cond;
    assign pblk_active = (state_q == ST_ACTIVE);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        blk_cond_d = blk_cond_q;
        case (state_q)
            ST_IDLE: begin
                if (start_instr) begin
                    state_d    = ST_ACTIVE;
                    blk_cond_d = cond;
                    count_d    = (pblk_len > MAX_LEN) ? MAX_LEN : pblk_len;
                end
            end
            ST_ACTIVE: begin
                // pblk_start is ignored here; the instruction is a member
                if (instr_valid) begin
                    count_d = count_q - 2'd1;
                    if (count_q == 2'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= 2'd0;
            blk_cond_q <= COND_AL;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            blk_cond_q <= blk_cond_d;
        end
    end
`else
    logic unused_pblk;
    assign unused_pblk = ^{pblk_start, pblk_len};
    assign start_instr = 1'b0;
    assign eff_cond    = cond;
    assign pblk_active = 1'b0;
`endif

    // the block-opening instruction only sets up the block; it never executes
    assign exec = instr_valid & cond_ex & ~start_instr;

    always_comb begin
        flags_d = flags_q;
        if (exec && flag_w[1]) begin
            flags_d[FLAG_N] = alu_flags[FLAG_N];
            flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (exec && flag_w[0]) begin
            flags_d[FLAG_C] = alu_flags[FLAG_C];
            flags_d[FLAG_V] = alu_flags[FLAG_V];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // reset gates the requests directly so nothing leaks while it is low
    assign reg_write = reset & exec & reg_w & ~no_write;
    assign mem_write = reset & exec & mem_w;
    assign pc_src    = reset & exec & pcs;
    assign flags     = flags_q;

endmodule

// File: tb/tb_cond_logic_unit.sv
module tb_cond_logic_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       instr_valid = 1'b0;
    logic [2:0] cond = 3'b111;
    logic [3:0] alu_flags = 4'b0000;
    logic [1:0] flag_w = 2'b00;
    logic       pcs = 1'b0;
    logic       reg_w = 1'b0;
    logic       mem_w = 1'b0;
    logic       no_write = 1'b0;
    logic       pblk_start = 1'b0;
    logic [1:0] pblk_len = 2'd0;
    logic       pc_src, reg_write, mem_write, cond_ex, pblk_active;
    logic [3:0] flags;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    bit         m_n, m_z, m_c, m_v;
    bit         m_blk;
    int         m_left;
    logic [2:0] m_bcond;

    cond_logic_unit #(.MAX_PBLK(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .cond        (cond),
        .alu_flags   (alu_flags),
        .flag_w      (flag_w),
        .pcs         (pcs),
        .reg_w       (reg_w),
        .mem_w       (mem_w),
        .no_write    (no_write),
        .pblk_start  (pblk_start),
        .pblk_len    (pblk_len),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .cond_ex     (cond_ex),
        .flags       (flags),
        .pblk_active (pblk_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    function automatic bit ref_pass(input logic [2:0] c);
        int code;
        code = int'(c);
        if (code == 0) return m_z;
        if (code == 1) return m_n;
        if (code == 2) return (!m_z) && (m_n == m_v);
        if (code == 7) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        m_blk = 0; m_left = 0; m_bcond = 3'b111;
    endtask

    // Called just after a falling edge: drive, check, clock, update model.
    task automatic step(input string tag, input bit v, input logic [2:0] c,
                        input logic [3:0] alu, input logic [1:0] fw,
                        input bit p, input bit rw, input bit mw, input bit nw,
                        input bit ps, input logic [1:0] pl, input int exp_ce);
        logic [2:0] use_c;
        bit ce, st, ex;
        instr_valid = v; cond = c; alu_flags = alu; flag_w = fw;
        pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
        pblk_start = ps; pblk_len = pl;
        #1;
        use_c = m_blk ? m_bcond : c;
        ce = ref_pass(use_c);
        st = 1'b0;
`ifdef COND_PBLK_EN
        st = !m_blk && ps && v && (pl != 2'd0);
`endif
        ex = v && ce && !st;
        check({tag, "_cond_ex"}, {3'b0, cond_ex}, {3'b0, ce});
        check({tag, "_reg_write"}, {3'b0, reg_write}, {3'b0, ex && rw && !nw});
        check({tag, "_mem_write"}, {3'b0, mem_write}, {3'b0, ex && mw});
        check({tag, "_pc_src"}, {3'b0, pc_src}, {3'b0, ex && p});
        check({tag, "_flags"}, flags, {m_n, m_z, m_c, m_v});
        check({tag, "_pblk_active"}, {3'b0, pblk_active}, {3'b0, m_blk});
        if (exp_ce >= 0) check({tag, "_ce_const"}, {3'b0, cond_ex}, 4'(exp_ce));
        @(posedge clk);
        if (v) begin
            if (ex && fw[1]) begin m_n = alu[3]; m_z = alu[2]; end
            if (ex && fw[0]) begin m_c = alu[1]; m_v = alu[0]; end
            if (st) begin
                m_blk = 1;
                m_left = (int'(pl) > 3) ? 3 : int'(pl);
                m_bcond = c;
            end else if (m_blk) begin
                m_left--;
                if (m_left == 0) m_blk = 0;
            end
        end
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle with an executable request on the inputs.
    task automatic do_reset(input string tag);
        instr_valid = 1; cond = 3'b111; reg_w = 1; mem_w = 1; pcs = 1;
        no_write = 0; flag_w = 2'b00; pblk_start = 0; pblk_len = 0;
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_rst_flags"}, flags, 4'b0000);
        check({tag, "_rst_pblk_active"}, {3'b0, pblk_active}, 4'b0000);
        check({tag, "_rst_writes"}, {1'b0, reg_write, mem_write, pc_src}, 4'b0000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset("por");

        // flag update then EQ execution
        step("f_upd", 1, 3'b111, 4'b0100, 2'b10, 0, 0, 0, 0, 0, 2'd0, 1);
        check("f_upd_flags", flags, 4'b0100);
        step("f_eq", 1, 3'b000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 2'd0, 1);

        // failing condition suppresses writes and flag update
        do_reset("r_sup");
        step("sup", 1, 3'b000, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 2'd0, 0);
        check("sup_flags", flags, 4'b0000);
        step("sup_nw", 1, 3'b111, 4'b0000, 2'b00, 1, 1, 1, 1, 0, 2'd0, 1);

        // GT and reserved codes
        step("gt_set", 1, 3'b111, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 2'd0, 1);
        step("gt_nv11", 1, 3'b010, 4'b1000, 2'b11, 0, 1, 0, 0, 0, 2'd0, 1);
        step("gt_nv10", 1, 3'b010, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 2'd0, 0);
        step("rsv_100", 1, 3'b100, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 2'd0, 0);
        step("mi", 1, 3'b001, 4'b0000, 2'b00, 1, 0, 1, 0, 0, 2'd0, 1);

`ifdef COND_PBLK_EN
        // block of two with a stall between members; N=1, Z=0 here
        step("blk_start", 1, 3'b001, 4'b0000, 2'b00, 1, 1, 1, 0, 1, 2'd2, 1);
        step("blk_m1", 1, 3'b000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 2'd0, 1);
        step("blk_stall", 0, 3'b000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 2'd0, 1);
        step("blk_m2", 1, 3'b000, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 2'd3, 1);
        step("blk_done", 1, 3'b000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 2'd0, 0);
        check("blk_done_idle", {3'b0, pblk_active}, 4'b0000);
        step("len0", 1, 3'b111, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 2'd0, 1);
        check("len0_idle", {3'b0, pblk_active}, 4'b0000);

        // reset with two members still outstanding
        step("rb_start", 1, 3'b111, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 2'd3, 1);
        step("rb_m1", 1, 3'b000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 2'd0, 1);
        check("rb_active", {3'b0, pblk_active}, 4'b0001);
        do_reset("rb");
        step("rb_after", 1, 3'b000, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 2'd0, 0);
`else
        // block request ignored; instruction runs on its own cond (N=1)
        step("nb_start", 1, 3'b001, 4'b0000, 2'b00, 1, 1, 1, 0, 1, 2'd3, 1);
        check("nb_idle", {3'b0, pblk_active}, 4'b0000);
        step("nb_next", 1, 3'b000, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 2'd3, 0);
        check("nb_idle2", {3'b0, pblk_active}, 4'b0000);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset("rnd");
            end else begin
                step("rnd",
                     $urandom_range(0, 3) != 0,
                     3'($urandom_range(0, 7)),
                     4'($urandom_range(0, 15)),
                     2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) == 0,
                     2'($urandom_range(0, 3)),
                     -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
